clk_nco_bank: RTL and testbench

- Parametrised, multi-channel, fully synchronous clock-generation successor to the fixed two-output core PLL wrapper.
- Runs on the PLL output clock (e.g. 112 MHz) as `refclk`.
- Produces NUM_CH independent numerically-controlled clock enables and square-wave clocks with runtime-programmable frequency and phase.
- Provides a `locked` indication that drops on every reconfiguration and re-asserts after a fixed settle time; feeds per-core clock-enable trees (CPU, audio, video).

---
 rtl/clk_nco_bank.sv | 141 ++++++++++++++
 tb/tb_clk_nco_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_nco_bank.sv
// +--------------------------------------------------------------------------+
// | Module   : clk_nco_bank                                                  |
// | Purpose  : Bank of NUM_CH numerically-controlled clock generators.       |
// |            Each channel has a phase accumulator stepped by a live        |
// |            increment. A wrap produces a one-cycle enable (ce), and the   |
// |            accumulator MSB is the square-wave clock (outclk).            |
// |            Increment and phase are staged in shadow registers. A single  |
// |            cfg_apply pulse loads all channels at the same instant, so    |
// |            they keep a known relative phase.                             |
// |            locked drops on reset or apply. It rises again after          |
// |            LOCK_CYCLES edges with no apply.                              |
// | Ports    : refclk    - clock, all logic on the rising edge               |
// |            rst       - synchronous active-high reset                     |
// |            cfg_we    - shadow register write strobe                      |
// |            cfg_ch    - channel addressed by the write                    |
// |            cfg_sel   - 0: increment shadow, 1: phase shadow              |
// |            cfg_data  - value written to the shadow                       |
// |            cfg_apply - copy shadows to live, realign accumulators        |
// |            ce        - per-channel one-cycle pulse after a wrap          |
// |            outclk    - per-channel square wave (accumulator MSB)         |
// |            locked    - configuration stable for LOCK_CYCLES cycles       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module clk_nco_bank #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int              CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Per-channel shadow registers and accumulator
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] r_shadow_incr;
    logic [ACC_W-1:0] r_shadow_phase;
    logic [ACC_W-1:0] r_live_incr;
    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;
    logic             w_hit;

    // Channel addresses past NUM_CH-1 match no channel.
    // Writes to those addresses are dropped.
    assign w_hit = cfg_we && (cfg_ch == CH_W'(i));

    always_ff @(posedge refclk) begin
      if (rst) begin
        r_shadow_incr  <= '0;
        r_shadow_phase <= '0;
      end else if (w_hit) begin
        if (cfg_sel) r_shadow_phase <= cfg_data;
        else         r_shadow_incr  <= cfg_data;
      end
    end

    // The extra top bit of the sum is the wrap carry.
    assign w_sum = {1'b0, r_acc} + {1'b0, r_live_incr};

    // Apply reads the shadows before this edge's write lands.
    // A write and an apply on the same edge therefore load the old value.
    always_ff @(posedge refclk) begin
      if (rst) begin
        r_live_incr <= '0;
        r_acc       <= '0;
        r_ce        <= 1'b0;
      end else if (cfg_apply) begin
        r_live_incr <= r_shadow_incr;
        r_acc       <= r_shadow_phase;
        r_ce        <= 1'b0;
      end else begin
        r_acc       <= w_sum[ACC_W-1:0];
        r_ce        <= w_sum[ACC_W];
      end
    end

    assign ce[i]     = r_ce;
    assign outclk[i] = r_acc[ACC_W-1];
  end

  // --------------------------------------------------------------------------
  // Lock FSM
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_locked;

  always_ff @(posedge refclk) begin
    if (rst || cfg_apply) begin
      r_state  <= ST_SETTLE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          // The counter stops at its last value and never wraps.
          if (r_cnt == c_CNT_LAST) begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          r_locked <= 1'b1;
        end
        default: begin
          r_state  <= ST_SETTLE;
          r_cnt    <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_clk_nco_bank.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_clk_nco_bank                                               |
// | Purpose  : Self-checking bench for clk_nco_bank.                         |
// |            DUT parameters: NUM_CH=3, ACC_W=16, LOCK_CYCLES=16.           |
// |            Stimulus is a directed vector table followed by hand-written  |
// |            multi-cycle sequences.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_clk_nco_bank;

  logic        refclk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = 2'd0;
  logic        cfg_sel = 1'b0;
  logic [15:0] cfg_data = 16'h0;
  logic        cfg_apply = 1'b0;
  logic [2:0]  ce;
  logic [2:0]  outclk;
  logic        locked;

  int errors = 0;
  int checks = 0;

  clk_nco_bank #(
    .NUM_CH(3),
    .ACC_W(16),
    .LOCK_CYCLES(16)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .cfg_apply(cfg_apply),
    .ce       (ce),
    .outclk   (outclk),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  ch;
    logic        sel;
    logic [15:0] data;
    logic        apply;
    logic [2:0]  ce;
    logic [2:0]  oc;
    logic        lk;
  } vec_t;

  vec_t vecs[11];

  // Drive one edge's inputs, take the edge, then return the inputs to idle.
  // Outputs are sampled 1 time unit after the edge.
  task automatic tick(input logic r, input logic we, input logic [1:0] ch,
                      input logic sel, input logic [15:0] d, input logic ap);
    rst = r; cfg_we = we; cfg_ch = ch; cfg_sel = sel; cfg_data = d; cfg_apply = ap;
    @(posedge refclk);
    #1;
    rst = 1'b0; cfg_we = 1'b0; cfg_apply = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] ce_e,
                            input logic [2:0] oc_e, input logic lk_e);
    chk({tag, ".ce"}, 32'(ce), 32'(ce_e));
    chk({tag, ".outclk"}, 32'(outclk), 32'(oc_e));
    chk({tag, ".locked"}, 32'(locked), 32'(lk_e));
  endtask

  // Expected outputs k edges after an apply with this live configuration:
  //   ch0: incr 0x2000, phase 0x0000
  //   ch1: incr 0x2000, phase 0x8000
  //   ch2: incr 0x1000, phase 0x0000
  task automatic check_full(input int k, input string tag);
    logic [2:0] ce_e;
    logic [2:0] oc_e;
    ce_e[0] = (k % 8 == 0);
    ce_e[1] = (k % 8 == 4);
    ce_e[2] = (k % 16 == 0);
    oc_e[0] = ((k % 8) >= 4);
    oc_e[1] = !oc_e[0];
    oc_e[2] = ((k % 16) >= 8);
    check_outs(tag, ce_e, oc_e, k >= 16);
  endtask

  initial begin
    logic [2:0] ce_e;
    logic [2:0] oc_e;

    // Fields: rst, we, ch, sel, data, apply, expected ce, outclk, locked.
    // ch0 incr = 0x4000 gives acc = 4000, 8000, C000, 0000 after E1..E4.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 16'h4000, 1'b0, 3'b000, 3'b000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 3'b000, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b000, 3'b001, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b000, 3'b001, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b001, 3'b000, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b000, 3'b001, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b000, 3'b001, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 3'b001, 3'b000, 1'b0};

    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].rst, vecs[i].we, vecs[i].ch, vecs[i].sel, vecs[i].data, vecs[i].apply);
      check_outs($sformatf("vec%0d", i), vecs[i].ce, vecs[i].oc, vecs[i].lk);
    end

    // Continue from the apply in vecs[2] (E0). locked must rise at E16.
    for (int k = 9; k <= 16; k++) begin
      idle();
      ce_e = {2'b00, (k % 4 == 0)};
      oc_e = {2'b00, ((k % 4) >= 2)};
      check_outs($sformatf("run4000_k%0d", k), ce_e, oc_e, k >= 16);
    end

    // Shadow writes while LOCKED leave locked high.
    tick(1'b0, 1'b1, 2'd1, 1'b0, 16'h2000, 1'b0);
    chk("we_keeps_lock_a", 32'(locked), 32'd1);
    tick(1'b0, 1'b1, 2'd1, 1'b1, 16'h8000, 1'b0);
    chk("we_keeps_lock_b", 32'(locked), 32'd1);
    tick(1'b0, 1'b1, 2'd0, 1'b0, 16'h2000, 1'b0);
    chk("we_keeps_lock_c", 32'(locked), 32'd1);

    // ch0/ch1 at 180 degrees: ce[1] leads ce[0] by 4, outclk complementary.
    tick(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    check_outs("quad_apply", 3'b000, 3'b010, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      idle();
      ce_e = {1'b0, (k % 8 == 4), (k % 8 == 0)};
      oc_e[0] = ((k % 8) >= 4);
      oc_e[1] = !oc_e[0];
      oc_e[2] = 1'b0;
      check_outs($sformatf("quad_k%0d", k), ce_e, oc_e, k >= 16);
    end

    // A second apply at E10 restarts the lock count: locked rises at E26.
    tick(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    for (int k = 1; k <= 9; k++) idle();
    chk("restart_pre_lock", 32'(locked), 32'd0);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      idle();
      chk($sformatf("restart_lock_E%0d", 10 + j), 32'(locked), 32'(j >= 16));
    end

    // A write on the apply edge lands in the shadow only. ch2 keeps incr 0.
    tick(1'b0, 1'b1, 2'd2, 1'b0, 16'h1000, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      idle();
      chk($sformatf("wa_ch2_ce_k%0d", k), 32'(ce[2]), 32'd0);
      chk($sformatf("wa_ch2_oc_k%0d", k), 32'(outclk[2]), 32'd0);
      chk($sformatf("wa_ch0_ce_k%0d", k), 32'(ce[0]), 32'(k % 8 == 0));
    end
    // The next apply picks up ch2 incr 0x1000, so ce[2] has period 16.
    tick(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    check_outs("full_apply", 3'b000, 3'b010, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      idle();
      check_full(k, $sformatf("full_k%0d", k));
    end

    // cfg_ch = NUM_CH addresses nothing, so a later apply changes nothing.
    tick(1'b0, 1'b1, 2'd3, 1'b0, 16'hFFFF, 1'b0);
    tick(1'b0, 1'b1, 2'd3, 1'b1, 16'h7777, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      idle();
      check_full(k, $sformatf("oor_k%0d", k));
    end

    // Reset mid-run overrides a same-edge apply and write.
    tick(1'b1, 1'b1, 2'd0, 1'b0, 16'h4000, 1'b1);
    check_outs("rst_mid", 3'b000, 3'b000, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      idle();
      check_outs($sformatf("post_rst_k%0d", k), 3'b000, 3'b000, k >= 16);
    end
    // The shadows were cleared, so an apply still yields silent channels.
    tick(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      idle();
      check_outs($sformatf("post_rst_apply_k%0d", k), 3'b000, 3'b000, k >= 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
